fixed_point_requant_pipe: RTL and testbench

//  Pipelined, multi-lane requantiser/saturator between the FC MAC/adder datapath and the layer writeback.

---
 rtl/fxp_pkg.sv | 19 +
 rtl/fxp_lane_sat.sv | 72 +++++++
 rtl/fixed_point_requant_pipe.sv | 143 ++++++++++++++
 tb/tb_fixed_point_requant_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
`default_nettype none
// ============================================================================
// Module : fxp_pkg
// Brief  : Shared types and Q5.11 constants for the requantiser datapath.
// Rev    : 1.0  initial release
// ============================================================================
package fxp_pkg;

    typedef enum logic {
        FXP_MODE_ADD = 1'b0,
        FXP_MODE_MUL = 1'b1
    } fxp_mode_e;

    localparam logic [15:0] FXP_MAX      = 16'h7FFF;
    localparam logic [15:0] FXP_MIN      = 16'h8000;
    localparam int          FXP_OUT_FRAC = 11;

endpackage
`default_nettype wire

// File: rtl/fxp_lane_sat.sv
`default_nettype none
// ============================================================================
// Module : fxp_lane_sat
// Brief  : Combinational shift (+ optional round, FXP_ROUND_EN) and clamp
//          for one lane; the caller registers between the two halves.
// Rev    : 1.0  initial release
// ============================================================================
module fxp_lane_sat
    import fxp_pkg::*;
#(
    parameter int IN_W     = 32,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 11,
    parameter int FRAC_MUL = 22,
    parameter int FRAC_ADD = 11
) (
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_mode,
    output logic [IN_W:0]    o_shifted,
    input  logic [IN_W:0]    i_shifted,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat_hi,
    output logic             o_sat_lo
);

    localparam int SH_MUL = FRAC_MUL - OUT_FRAC;
    localparam int SH_ADD = FRAC_ADD - OUT_FRAC;
    localparam logic [IN_W:0] c_ONE = {{IN_W{1'b0}}, 1'b1};

`ifdef FXP_ROUND_EN
    // Half of the dropped LSB weight; zero when nothing is shifted out.
    localparam logic [IN_W:0] c_RND_MUL = (c_ONE << SH_MUL) >> 1;
    localparam logic [IN_W:0] c_RND_ADD = (c_ONE << SH_ADD) >> 1;
`else
    localparam logic [IN_W:0] c_RND_MUL = '0;
    localparam logic [IN_W:0] c_RND_ADD = '0;
`endif

    localparam logic signed [IN_W:0] c_HI =
        {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] c_LO =
        {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_sum_mul;
    logic signed [IN_W:0] w_sum_add;
    logic signed [IN_W:0] w_sh_mul;
    logic signed [IN_W:0] w_sh_add;
    logic signed [IN_W:0] w_v;

    assign w_ext     = $signed({i_data[IN_W-1], i_data});
    assign w_sum_mul = w_ext + $signed(c_RND_MUL);
    assign w_sum_add = w_ext + $signed(c_RND_ADD);
    assign w_sh_mul  = w_sum_mul >>> SH_MUL;
    assign w_sh_add  = w_sum_add >>> SH_ADD;
    assign o_shifted = (fxp_mode_e'(i_mode) == FXP_MODE_MUL) ? w_sh_mul : w_sh_add;

    assign w_v      = $signed(i_shifted);
    assign o_sat_hi = (w_v > c_HI);
    assign o_sat_lo = (w_v < c_LO);

    always_comb begin
        o_data = i_shifted[OUT_W-1:0];
        if (o_sat_hi) begin
            o_data = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (o_sat_lo) begin
            o_data = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fixed_point_requant_pipe.sv
`default_nettype none
// ============================================================================
// Module : fixed_point_requant_pipe
// Brief  : Two-stage valid/ready requantiser (Q.22/Q.11 -> Q5.11) with
//          per-lane saturation flags and sticky counters. Option: FXP_ROUND_EN.
// Rev    : 1.0  initial release
// ============================================================================
module fixed_point_requant_pipe
    import fxp_pkg::*;
#(
    parameter int IN_W     = 32,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = FXP_OUT_FRAC,
    parameter int FRAC_MUL = 22,
    parameter int FRAC_ADD = 11,
    parameter int LANES    = 1,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [LANES*IN_W-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       sat_hi_cnt,
    output logic [CNT_W-1:0]       sat_lo_cnt
);

    localparam int PW = $clog2(LANES + 1);

    if ((FRAC_MUL < OUT_FRAC) || (FRAC_ADD < OUT_FRAC) || (OUT_W > IN_W)) begin : g_param_err
        $error("fixed_point_requant_pipe: illegal FRAC_MUL/FRAC_ADD/OUT_W combination");
    end

    logic                       r_s1_valid;
    logic [LANES*(IN_W+1)-1:0]  r_s1_v;
    logic                       r_out_valid;
    logic [LANES*OUT_W-1:0]     r_out_data;
    logic [LANES-1:0]           r_sat_hi;
    logic [LANES-1:0]           r_sat_lo;
    logic [CNT_W-1:0]           r_hi_cnt;
    logic [CNT_W-1:0]           r_lo_cnt;

    logic                       w_s2_adv;
    logic                       w_s1_adv;
    logic                       w_out_fire;
    logic [LANES*(IN_W+1)-1:0]  w_shifted;
    logic [LANES*OUT_W-1:0]     w_clamped;
    logic [LANES-1:0]           w_sat_hi;
    logic [LANES-1:0]           w_sat_lo;
    logic [PW-1:0]              w_pop_hi;
    logic [PW-1:0]              w_pop_lo;
    logic [CNT_W:0]             w_hi_sum;
    logic [CNT_W:0]             w_lo_sum;

    assign w_s2_adv   = !r_out_valid || out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign in_ready   = w_s1_adv && !rst;
    assign w_out_fire = r_out_valid && out_ready;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        fxp_lane_sat #(
            .IN_W     (IN_W),
            .OUT_W    (OUT_W),
            .OUT_FRAC (OUT_FRAC),
            .FRAC_MUL (FRAC_MUL),
            .FRAC_ADD (FRAC_ADD)
        ) u_lane (
            .i_data    (in_data[gi*IN_W +: IN_W]),
            .i_mode    (in_mode),
            .o_shifted (w_shifted[gi*(IN_W+1) +: IN_W+1]),
            .i_shifted (r_s1_v[gi*(IN_W+1) +: IN_W+1]),
            .o_data    (w_clamped[gi*OUT_W +: OUT_W]),
            .o_sat_hi  (w_sat_hi[gi]),
            .o_sat_lo  (w_sat_lo[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_v     <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_v <= w_shifted;
            end
        end
    end

    // S2 only reloads on advance, which keeps the output stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat_hi    <= '0;
            r_sat_lo    <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_clamped;
                r_sat_hi   <= w_sat_hi;
                r_sat_lo   <= w_sat_lo;
            end
        end
    end

    always_comb begin
        w_pop_hi = '0;
        w_pop_lo = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop_hi = w_pop_hi + PW'(r_sat_hi[i]);
            w_pop_lo = w_pop_lo + PW'(r_sat_lo[i]);
        end
    end

    assign w_hi_sum = {1'b0, r_hi_cnt} + {{(CNT_W+1-PW){1'b0}}, w_pop_hi};
    assign w_lo_sum = {1'b0, r_lo_cnt} + {{(CNT_W+1-PW){1'b0}}, w_pop_lo};

    // Carry out of the sum means the counter would wrap; pin it at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
        end else if (w_out_fire) begin
            r_hi_cnt <= w_hi_sum[CNT_W] ? '1 : w_hi_sum[CNT_W-1:0];
            r_lo_cnt <= w_lo_sum[CNT_W] ? '1 : w_lo_sum[CNT_W-1:0];
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_sat    = r_sat_hi | r_sat_lo;
    assign sat_hi_cnt = r_hi_cnt;
    assign sat_lo_cnt = r_lo_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_requant_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_fixed_point_requant_pipe
// Brief  : Directed self-checking bench for fixed_point_requant_pipe.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fixed_point_requant_pipe;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [0:0]  out_sat;
    logic        cnt_clr = 1'b0;
    logic [CNT_W-1:0] sat_hi_cnt;
    logic [CNT_W-1:0] sat_lo_cnt;

    int checks = 0;
    int errors = 0;

    fixed_point_requant_pipe #(
        .IN_W(32), .OUT_W(16), .OUT_FRAC(11), .FRAC_MUL(22), .FRAC_ADD(11),
        .LANES(1), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .cnt_clr    (cnt_clr),
        .sat_hi_cnt (sat_hi_cnt),
        .sat_lo_cnt (sat_lo_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sample through an empty pipe with out_ready=1; lat counts edges incl. the handshake edge.
    task automatic xfer(input logic [31:0] d, input logic m,
                        output logic [15:0] od, output logic os, output int lat);
        int n;
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        od = out_data;
        os = out_sat[0];
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h sat=%b, want 0/0000/0",
                     out_valid, out_data, out_sat);
        end
        checks++;
        if (sat_hi_cnt !== '0 || sat_lo_cnt !== '0) begin
            errors++;
            $display("FAIL reset_counters: got hi=%0d lo=%0d, want 0/0", sat_hi_cnt, sat_lo_cnt);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic check_sample(input string name, input logic [31:0] d, input logic m,
                                input logic [15:0] ed, input logic es);
        logic [15:0] od;
        logic        os;
        int          lat;
        xfer(d, m, od, os, lat);
        checks++;
        if (od !== ed || os !== es || lat !== 2) begin
            errors++;
            $display("FAIL %s: got data=%h sat=%b lat=%0d, want data=%h sat=%b lat=2",
                     name, od, os, lat, ed, es);
        end
    endtask

    task automatic check_counts(input string name, input int ehi, input int elo);
        checks++;
        if (sat_hi_cnt !== CNT_W'(ehi) || sat_lo_cnt !== CNT_W'(elo)) begin
            errors++;
            $display("FAIL %s: got hi=%0d lo=%0d, want hi=%0d lo=%0d",
                     name, sat_hi_cnt, sat_lo_cnt, ehi, elo);
        end
    endtask

    task automatic test_mul_bounds();
        check_sample("mul_16p0",   32'h0400_0000, 1'b1, 16'h7FFF, 1'b1);
        check_counts("cnt_after_mul_16p0", 1, 0);
        check_sample("mul_max",    32'h03FF_FFFF, 1'b1, 16'h7FFF, 1'b0);
        check_sample("mul_m16p0",  32'hFC00_0000, 1'b1, 16'h8000, 1'b0);
        check_sample("mul_below",  32'hFBFF_FFFF, 1'b1, 16'h8000, 1'b1);
        check_counts("cnt_after_mul_below", 1, 1);
    endtask

    task automatic test_add_format();
        check_sample("add_3p0",    32'h0000_1800, 1'b0, 16'h1800, 1'b0);
        check_sample("add_over",   32'h0000_8000, 1'b0, 16'h7FFF, 1'b1);
        check_sample("add_min",    32'hFFFF_8000, 1'b0, 16'h8000, 1'b0);
        check_sample("add_under",  32'hFFFF_7FFF, 1'b0, 16'h8000, 1'b1);
        check_counts("cnt_after_add", 2, 2);
    endtask

    task automatic test_round();
`ifdef FXP_ROUND_EN
        check_sample("mul_half_lsb",     32'h0000_0400, 1'b1, 16'h0001, 1'b0);
        check_sample("mul_neg_half_lsb", 32'hFFFF_FC00, 1'b1, 16'h0000, 1'b0);
`else
        check_sample("mul_half_lsb",     32'h0000_0400, 1'b1, 16'h0000, 1'b0);
        check_sample("mul_neg_half_lsb", 32'hFFFF_FC00, 1'b1, 16'hFFFF, 1'b0);
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        logic [15:0] got [$];
        int k;
        int cyc;
        logic acc;
        vals[0] = 32'h0000_0100;
        vals[1] = 32'h0000_0200;
        vals[2] = 32'h0000_0300;
        vals[3] = 32'h0000_0400;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (k < 4);
            in_data  = (k < 4) ? vals[k] : 32'h0;
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
        end
        #1;
        checks++;
        if (k !== 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: got accepts=%0d in_ready=%b, want 2/0", k, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0100) begin
            errors++;
            $display("FAIL b2b_hold: got valid=%b data=%h, want 1/0100", out_valid, out_data);
        end
        out_ready = 1'b1;
        cyc = 0;
        while (got.size() < 4 && cyc < 30) begin
            in_valid = (k < 4);
            in_data  = (k < 4) ? vals[k] : 32'h0;
            #1;
            acc = in_valid && in_ready;
            if (out_valid) got.push_back(out_data);
            tick();
            if (acc) k++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== vals[i][15:0]) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got %h want %h", i, got[i], vals[i][15:0]);
                end
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_dup: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_cnt_clr();
        int n;
        logic [15:0] od;
        logic os;
        int lat;
        out_ready = 1'b1;
        in_data   = 32'h0400_0000;
        in_mode   = 1'b1;
        in_valid  = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL clr_setup: got valid=%b sat=%b want 1/1", out_valid, out_sat);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_counts("cnt_clr_wins", 0, 0);
        xfer(32'h0400_0000, 1'b1, od, os, lat);
        check_counts("cnt_after_clr", 1, 0);
    endtask

    task automatic test_sticky();
        int acc_n;
        int got_n;
        int cyc;
        logic acc;
        cnt_clr = 1'b1;
        tick();
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        in_data   = 32'h0400_0000;
        in_mode   = 1'b1;
        acc_n = 0;
        got_n = 0;
        cyc   = 0;
        while (got_n < 20 && cyc < 60) begin
            in_valid = (acc_n < 20);
            #1;
            acc = in_valid && in_ready;
            if (out_valid) got_n++;
            tick();
            if (acc) acc_n++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got_n !== 20) begin
            errors++;
            $display("FAIL sticky_stream: got %0d outputs want 20", got_n);
        end
        check_counts("cnt_sticky", 15, 0);
    endtask

    task automatic test_reset_mid();
        int stale;
        out_ready = 1'b0;
        in_data   = 32'h0400_0000;
        in_mode   = 1'b1;
        in_valid  = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b in_ready=%b want 0/0", out_valid, in_ready);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (out_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL mid_reset_stale: got %0d stale outputs want 0", stale);
        end
        check_counts("mid_reset_cnt", 0, 0);
    endtask

    initial begin
        test_reset();
        test_mul_bounds();
        test_add_format();
        test_round();
        test_back_to_back();
        test_cnt_clr();
        test_sticky();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
